// File: rtl/tm_pkg.sv
// Shared types for the Turing machine rule loader and core: rule word layout,
// move encoding and loader state encoding.
package tm_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned NUM_FIELDS = 4;

  // Head move direction lives in bit 1 of the write_move field
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } move_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] cur_state;
    logic [DATA_W_DEF-1:0] read_sym;
    logic [DATA_W_DEF-1:0] write_move;
    logic [DATA_W_DEF-1:0] next_state;
  } rule_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_FULL    = 2'd2,
    ST_LOADED  = 2'd3
  } loader_state_e;

  function automatic move_e rule_move(input rule_t r);
    return move_e'(r.write_move[1]);
  endfunction

endpackage

// File: rtl/tm_button_pulse.sv
// Push-button conditioner: optional 2-flop synchroniser (TM_RULE_LOADER_SYNC_EN)
// followed by a rising-edge detector emitting one registered 1-cycle pulse per press.
module tm_button_pulse (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic w_level;
  logic r_prev;
  logic r_pulse;

`ifdef TM_RULE_LOADER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_btn};
  end

  assign w_level = r_sync[1];
`else
  logic r_sample;

  always_ff @(posedge clock) begin
    if (reset) r_sample <= 1'b0;
    else       r_sample <= i_btn;
  end

  assign w_level = r_sample;
`endif

  // Edge history and registered pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/tm_rule_loader.sv
// Hand-keyed rule entry: packs four keyed fields into a rule word, writes it to
// the core's rule table and hands over on Done. Macro: TM_RULE_LOADER_SYNC_EN.
module tm_rule_loader
  import tm_pkg::*;
#(
  parameter int unsigned NUM_RULES = 16,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            input_data,
  input  logic                         Next,
  input  logic                         Done,
  output logic                         rule_we,
  output logic [$clog2(NUM_RULES)-1:0] rule_addr,
  output logic [4*DATA_W-1:0]          rule_data,
  output logic [1:0]                   field_idx,
  output logic [$clog2(NUM_RULES):0]   rule_count,
  output logic                         loaded,
  output logic                         entry_err
);

  localparam int unsigned AW = $clog2(NUM_RULES);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = NUM_FIELDS * DATA_W;

  logic w_next_pulse;
  logic w_done_pulse;

  loader_state_e r_state;
  loader_state_e w_state_nxt;

  logic          r_rule_we;
  logic [AW-1:0] r_rule_addr;
  logic [RW-1:0] r_rule_data;
  logic [1:0]    r_field_idx;
  logic [CW-1:0] r_rule_count;
  logic          r_loaded;
  logic          r_entry_err;

  logic          w_rule_we_nxt;
  logic [AW-1:0] w_rule_addr_nxt;
  logic [RW-1:0] w_rule_data_nxt;
  logic [1:0]    w_field_idx_nxt;
  logic [CW-1:0] w_rule_count_nxt;
  logic          w_loaded_nxt;
  logic          w_entry_err_nxt;

  tm_button_pulse u_next_btn (
    .clock   (clock),
    .reset   (reset),
    .i_btn   (Next),
    .o_pulse (w_next_pulse)
  );

  tm_button_pulse u_done_btn (
    .clock   (clock),
    .reset   (reset),
    .i_btn   (Done),
    .o_pulse (w_done_pulse)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_COLLECT;
    else       r_state <= w_state_nxt;
  end

  // Done always wins over a coincident Next
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_done_pulse)                               w_state_nxt = ST_LOADED;
        else if (w_next_pulse && (r_field_idx == 2'd3)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (w_done_pulse)                                  w_state_nxt = ST_LOADED;
        else if (r_rule_count == CW'(NUM_RULES - 1))       w_state_nxt = ST_FULL;
        else                                               w_state_nxt = ST_COLLECT;
      end
      ST_FULL: begin
        if (w_done_pulse) w_state_nxt = ST_LOADED;
      end
      default: w_state_nxt = ST_LOADED;
    endcase
  end

  always_comb begin
    w_rule_we_nxt    = 1'b0;
    w_rule_addr_nxt  = r_rule_addr;
    w_rule_data_nxt  = r_rule_data;
    w_field_idx_nxt  = r_field_idx;
    w_rule_count_nxt = r_rule_count;
    w_entry_err_nxt  = r_entry_err;
    w_loaded_nxt     = (w_state_nxt == ST_LOADED);
    case (r_state)
      ST_COLLECT: begin
        if (w_done_pulse) begin
          if (r_field_idx != 2'd0) begin
            w_entry_err_nxt = 1'b1;
            w_field_idx_nxt = 2'd0;
            w_rule_data_nxt = '0;
          end
        end else if (w_next_pulse) begin
          // Field 0 occupies the MSBs of the rule word
          for (int i = 0; i < 4; i++) begin
            if (r_field_idx == 2'(i)) w_rule_data_nxt[(3-i)*DATA_W +: DATA_W] = input_data;
          end
          w_field_idx_nxt = r_field_idx + 2'd1;
          if (r_field_idx == 2'd3) begin
            w_rule_we_nxt   = 1'b1;
            w_rule_addr_nxt = r_rule_count[AW-1:0];
          end
        end
      end
      ST_COMMIT: begin
        w_rule_count_nxt = r_rule_count + CW'(1);
        w_field_idx_nxt  = 2'd0;
      end
      ST_FULL: begin
        if (w_next_pulse && !w_done_pulse) w_entry_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rule_we    <= 1'b0;
      r_rule_addr  <= '0;
      r_rule_data  <= '0;
      r_field_idx  <= 2'd0;
      r_rule_count <= '0;
      r_loaded     <= 1'b0;
      r_entry_err  <= 1'b0;
    end else begin
      r_rule_we    <= w_rule_we_nxt;
      r_rule_addr  <= w_rule_addr_nxt;
      r_rule_data  <= w_rule_data_nxt;
      r_field_idx  <= w_field_idx_nxt;
      r_rule_count <= w_rule_count_nxt;
      r_loaded     <= w_loaded_nxt;
      r_entry_err  <= w_entry_err_nxt;
    end
  end

  assign rule_we    = r_rule_we;
  assign rule_addr  = r_rule_addr;
  assign rule_data  = r_rule_data;
  assign field_idx  = r_field_idx;
  assign rule_count = r_rule_count;
  assign loaded     = r_loaded;
  assign entry_err  = r_entry_err;

endmodule

// File: tb/tb_tm_rule_loader.sv
// Self-checking bench for tm_rule_loader with a 4-entry rule table: vector table,
// hand-written corner sequences and randomized key presses against a queue model.
module tb_tm_rule_loader;
  import tm_pkg::*;

  localparam int NR = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  input_data;
  logic        Next;
  logic        Done;
  logic        rule_we;
  logic [1:0]  rule_addr;
  logic [15:0] rule_data;
  logic [1:0]  field_idx;
  logic [2:0]  rule_count;
  logic        loaded;
  logic        entry_err;

  int n_checks = 0;
  int n_fails  = 0;

  int          n_we = 0;
  logic [1:0]  last_addr;
  logic [15:0] last_data;
  logic [1:0]  mon_addr_q[$];
  logic [15:0] mon_data_q[$];

  tm_rule_loader #(.NUM_RULES(NR), .DATA_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .input_data (input_data),
    .Next       (Next),
    .Done       (Done),
    .rule_we    (rule_we),
    .rule_addr  (rule_addr),
    .rule_data  (rule_data),
    .field_idx  (field_idx),
    .rule_count (rule_count),
    .loaded     (loaded),
    .entry_err  (entry_err)
  );

  always #5 clock = ~clock;

  // Record every table write seen by the core
  always @(negedge clock) begin
    if (rule_we === 1'b1) begin
      n_we++;
      last_addr = rule_addr;
      last_data = rule_data;
      mon_addr_q.push_back(rule_addr);
      mon_data_q.push_back(rule_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    Next  = 1'b0;
    Done  = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    mon_addr_q.delete();
    mon_data_q.delete();
  endtask

  // One button press: hold, release, then idle long enough for capture/commit
  task automatic press(input logic nx, input logic dn, input logic [3:0] v, input int hold);
    @(negedge clock);
    input_data = v;
    Next = nx;
    Done = dn;
    repeat (hold) @(negedge clock);
    Next = 1'b0;
    Done = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  typedef struct {
    logic [3:0]  f0, f1, f2, f3;
    logic [15:0] exp_data;
    logic [1:0]  exp_addr;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[4];

  // Behavioural model state for randomized rounds
  logic [3:0]  m_fields[$];
  int          m_count;
  logic        m_err;
  logic        m_loaded;
  logic [1:0]  m_addr_q[$];
  logic [15:0] m_data_q[$];

  task automatic model_next(input logic [3:0] v);
    rule_t r;
    if (m_loaded) return;
    if (m_count == NR) begin
      m_err = 1'b1;
      return;
    end
    m_fields.push_back(v);
    if (m_fields.size() == 4) begin
      r.cur_state  = m_fields[0];
      r.read_sym   = m_fields[1];
      r.write_move = m_fields[2];
      r.next_state = m_fields[3];
      m_addr_q.push_back(2'(m_count));
      m_data_q.push_back(r);
      m_count++;
      m_fields.delete();
    end
  endtask

  task automatic model_done();
    if (m_loaded) return;
    if (m_fields.size() != 0) m_err = 1'b1;
    m_fields.delete();
    m_loaded = 1'b1;
  endtask

  initial begin
    int base;
    string nm;
    input_data = 4'h0;
    Next  = 1'b0;
    Done  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_we",    32'(rule_we),    32'd0);
    check("reset_addr",  32'(rule_addr),  32'd0);
    check("reset_data",  32'(rule_data),  32'd0);
    check("reset_idx",   32'(field_idx),  32'd0);
    check("reset_count", 32'(rule_count), 32'd0);
    check("reset_load",  32'(loaded),     32'd0);
    check("reset_err",   32'(entry_err),  32'd0);

    // Table: four full rules fill the table, then overflow and Done
    vecs[0] = '{4'h3, 4'h1, 4'h0, 4'h2, 16'h3102, 2'd0, 3'd1};
    vecs[1] = '{4'h2, 4'h0, 4'h2, 4'h3, 16'h2023, 2'd1, 3'd2};
    vecs[2] = '{4'hF, 4'hE, 4'h3, 4'h9, 16'hFE39, 2'd2, 3'd3};
    vecs[3] = '{4'h0, 4'h5, 4'hC, 4'h1, 16'h05C1, 2'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      base = n_we;
      press(1'b1, 1'b0, vecs[i].f0, 2);
      check($sformatf("vec%0d_idx1", i), 32'(field_idx), 32'd1);
      press(1'b1, 1'b0, vecs[i].f1, 2);
      check($sformatf("vec%0d_idx2", i), 32'(field_idx), 32'd2);
      press(1'b1, 1'b0, vecs[i].f2, 2);
      check($sformatf("vec%0d_idx3", i), 32'(field_idx), 32'd3);
      press(1'b1, 1'b0, vecs[i].f3, 2);
      check($sformatf("vec%0d_nwe", i),   32'(n_we - base),  32'd1);
      check($sformatf("vec%0d_addr", i),  32'(last_addr),    32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i),  32'(last_data),    32'(vecs[i].exp_data));
      check($sformatf("vec%0d_count", i), 32'(rule_count),   32'(vecs[i].exp_count));
      check($sformatf("vec%0d_idx0", i),  32'(field_idx),    32'd0);
      check($sformatf("vec%0d_err", i),   32'(entry_err),    32'd0);
    end
    base = n_we;
    press(1'b1, 1'b0, 4'h7, 2);
    check("ovf_nwe",   32'(n_we - base), 32'd0);
    check("ovf_err",   32'(entry_err),   32'd1);
    check("ovf_load0", 32'(loaded),      32'd0);
    press(1'b0, 1'b1, 4'h7, 2);
    check("ovf_load1", 32'(loaded),      32'd1);
    check("ovf_count", 32'(rule_count),  32'd4);

    // Held button: a long press captures once
    do_reset();
    base = n_we;
    press(1'b1, 1'b0, 4'h5, 10);
    check("hold_idx",  32'(field_idx),   32'd1);
    check("hold_data", 32'(rule_data),   32'h5000);
    check("hold_nwe",  32'(n_we - base), 32'd0);

    // Partial rule then Done
    do_reset();
    base = n_we;
    press(1'b1, 1'b0, 4'h1, 2);
    press(1'b1, 1'b0, 4'h0, 2);
    press(1'b0, 1'b1, 4'h0, 2);
    check("part_nwe",  32'(n_we - base), 32'd0);
    check("part_err",  32'(entry_err),   32'd1);
    check("part_load", 32'(loaded),      32'd1);

    // Simultaneous press at field 0, then presses after loading are ignored
    do_reset();
    base = n_we;
    press(1'b1, 1'b1, 4'h9, 2);
    check("simul_load", 32'(loaded),    32'd1);
    check("simul_err",  32'(entry_err), 32'd0);
    check("simul_idx",  32'(field_idx), 32'd0);
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 4'h7, 2);
    check("ign_load",  32'(loaded),      32'd1);
    check("ign_err",   32'(entry_err),   32'd0);
    check("ign_idx",   32'(field_idx),   32'd0);
    check("ign_count", 32'(rule_count),  32'd0);
    check("ign_data",  32'(rule_data),   32'd0);
    check("ign_nwe",   32'(n_we - base), 32'd0);

    // Reset mid-entry, then a fresh rule lands at address 0
    do_reset();
    press(1'b1, 1'b0, 4'h4, 2);
    press(1'b1, 1'b0, 4'h6, 2);
    check("mid_idx_pre", 32'(field_idx), 32'd2);
    do_reset();
    check("mid_we",    32'(rule_we),    32'd0);
    check("mid_addr",  32'(rule_addr),  32'd0);
    check("mid_data",  32'(rule_data),  32'd0);
    check("mid_idx",   32'(field_idx),  32'd0);
    check("mid_count", 32'(rule_count), 32'd0);
    check("mid_load",  32'(loaded),     32'd0);
    check("mid_err",   32'(entry_err),  32'd0);
    base = n_we;
    press(1'b1, 1'b0, 4'h2, 2);
    press(1'b1, 1'b0, 4'h0, 2);
    press(1'b1, 1'b0, 4'h2, 2);
    press(1'b1, 1'b0, 4'h3, 2);
    check("mid2_nwe",   32'(n_we - base), 32'd1);
    check("mid2_data",  32'(last_data),   32'h2023);
    check("mid2_addr",  32'(last_addr),   32'd0);
    check("mid2_count", 32'(rule_count),  32'd1);

    // Randomized press sequences against the queue model
    for (int r = 0; r < 10; r++) begin
      int n_ops;
      do_reset();
      m_fields.delete();
      m_addr_q.delete();
      m_data_q.delete();
      m_count  = 0;
      m_err    = 1'b0;
      m_loaded = 1'b0;
      n_ops = $urandom_range(4, 24);
      for (int k = 0; k < n_ops; k++) begin
        int x;
        logic [3:0] v;
        x = $urandom_range(0, 99);
        v = 4'($urandom_range(0, 15));
        if (x < 82) begin
          press(1'b1, 1'b0, v, $urandom_range(1, 4));
          model_next(v);
        end else if (x < 93) begin
          press(1'b0, 1'b1, v, $urandom_range(1, 4));
          model_done();
        end else begin
          press(1'b1, 1'b1, v, $urandom_range(1, 4));
          model_done();
        end
      end
      nm = $sformatf("rnd%0d", r);
      check({nm, "_count"}, 32'(rule_count), 32'(m_count));
      check({nm, "_idx"},   32'(field_idx),  32'(m_fields.size()));
      check({nm, "_err"},   32'(entry_err),  32'(m_err));
      check({nm, "_load"},  32'(loaded),     32'(m_loaded));
      check({nm, "_nwr"},   32'(mon_data_q.size()), 32'(m_data_q.size()));
      for (int i = 0; i < m_data_q.size() && i < mon_data_q.size(); i++) begin
        check($sformatf("%s_wdata%0d", nm, i), 32'(mon_data_q[i]), 32'(m_data_q[i]));
        check($sformatf("%s_waddr%0d", nm, i), 32'(mon_addr_q[i]), 32'(m_addr_q[i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
